// File: rtl/ex_fwd_scoreboard_pkg.sv
// Shared definitions for the EX forwarding / FPU scoreboard block:
// forward-select encoding, matcher mode and issue-state types.
package ex_fwd_scoreboard_pkg;

  // Select value meaning "take the operand from the register file".
  localparam int EX_FWD_NONE = 0;

  typedef enum logic {
    FWD_MODE_INT = 1'b0,
    FWD_MODE_FP  = 1'b1
  } fwd_mode_e;

  typedef enum logic {
    ISS_IDLE = 1'b0,
    ISS_DONE = 1'b1
  } iss_state_e;

  // One extra code beyond the stages is needed for EX_FWD_NONE.
  function automatic int fwd_sel_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  // Stage k is encoded as select value k+1.
  function automatic int stage_to_sel(input int stage);
    return stage + 1;
  endfunction

endpackage

// File: rtl/ex_fwd_scoreboard_fwd_match.sv
// Matches one source register against every forwarding stage and returns
// the priority-encoded select; the youngest (lowest index) stage wins.
module ex_fwd_scoreboard_fwd_match
  import ex_fwd_scoreboard_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int RIDX_W         = 5,
  parameter int FWD_W          = fwd_sel_w(NUM_FWD_STAGES)
) (
  input  fwd_mode_e                         mode_i,
  input  logic [RIDX_W-1:0]                 src_i,
  input  logic                              has_src_i,
  input  logic [NUM_FWD_STAGES*RIDX_W-1:0]  stg_rd_i,
  input  logic [NUM_FWD_STAGES-1:0]         stg_wen_int_i,
  input  logic [NUM_FWD_STAGES-1:0]         stg_wen_fp_i,
  output logic [FWD_W-1:0]                  sel_o
);

  logic                      src_ok;
  logic [NUM_FWD_STAGES-1:0] hit;

  // x0 is hardwired zero and never forwarded; f0 is an ordinary register.
  always_comb begin
    src_ok = has_src_i && ((mode_i == FWD_MODE_FP) || (src_i != '0));
    for (int k = 0; k < NUM_FWD_STAGES; k++) begin
      hit[k] = src_ok
            && ((mode_i == FWD_MODE_FP) ? stg_wen_fp_i[k] : stg_wen_int_i[k])
            && (stg_rd_i[k*RIDX_W +: RIDX_W] == src_i);
    end
  end

  always_comb begin
    sel_o = FWD_W'(EX_FWD_NONE);
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (hit[k]) sel_o = FWD_W'(stage_to_sel(k));
    end
  end

endmodule

// File: rtl/ex_fwd_scoreboard.sv
// EX-stage hazard unit: operand forward selects, one-shot FPU issue and a
// per-register scoreboard of in-flight multi-cycle FPU results.
module ex_fwd_scoreboard
  import ex_fwd_scoreboard_pkg::*;
#(
  parameter int NUM_FWD_STAGES  = 2,
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FWD_W           = fwd_sel_w(NUM_FWD_STAGES),
  parameter int RIDX_W          = $clog2(NUM_REGS),
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ex_valid,
  input  logic                              ex_advance,
  input  logic                              flush,
  input  logic [RIDX_W-1:0]                 rs1,
  input  logic [RIDX_W-1:0]                 rs2,
  input  logic                              has_rs1,
  input  logic                              has_rs2,
  input  logic [RIDX_W-1:0]                 fs1,
  input  logic [RIDX_W-1:0]                 fs2,
  input  logic [RIDX_W-1:0]                 fs3,
  input  logic                              has_fs1,
  input  logic                              has_fs2,
  input  logic                              has_fs3,
  input  logic                              ex_fp_op,
  input  logic                              ex_fp_multi,
  input  logic [RIDX_W-1:0]                 ex_fd,
  input  logic                              ex_has_fd,
  input  logic [NUM_FWD_STAGES*RIDX_W-1:0]  stg_rd,
  input  logic [NUM_FWD_STAGES-1:0]         stg_wen_int,
  input  logic [NUM_FWD_STAGES-1:0]         stg_wen_fp,
  input  logic                              fpu_ready,
  input  logic                              fpu_done,
  input  logic [RIDX_W-1:0]                 fpu_done_fd,
  output logic [FWD_W-1:0]                  fwda,
  output logic [FWD_W-1:0]                  fwdb,
  output logic [FWD_W-1:0]                  fwd_fpa,
  output logic [FWD_W-1:0]                  fwd_fpb,
  output logic [FWD_W-1:0]                  fwd_fpc,
  output logic                              fpu_valid,
  output logic                              stall,
  output logic [OUT_W-1:0]                  outstanding
);

  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  iss_state_e          iss_state_q, iss_state_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;

  logic issued, raw_haz, waw_haz, cap_haz, iss_stall, fire, set_en, clr_en;

  ex_fwd_scoreboard_fwd_match #(
    .NUM_FWD_STAGES(NUM_FWD_STAGES), .RIDX_W(RIDX_W), .FWD_W(FWD_W)
  ) u_fwd_a (
    .mode_i(FWD_MODE_INT), .src_i(rs1), .has_src_i(has_rs1), .stg_rd_i(stg_rd),
    .stg_wen_int_i(stg_wen_int), .stg_wen_fp_i(stg_wen_fp), .sel_o(fwda)
  );

  ex_fwd_scoreboard_fwd_match #(
    .NUM_FWD_STAGES(NUM_FWD_STAGES), .RIDX_W(RIDX_W), .FWD_W(FWD_W)
  ) u_fwd_b (
    .mode_i(FWD_MODE_INT), .src_i(rs2), .has_src_i(has_rs2), .stg_rd_i(stg_rd),
    .stg_wen_int_i(stg_wen_int), .stg_wen_fp_i(stg_wen_fp), .sel_o(fwdb)
  );

  ex_fwd_scoreboard_fwd_match #(
    .NUM_FWD_STAGES(NUM_FWD_STAGES), .RIDX_W(RIDX_W), .FWD_W(FWD_W)
  ) u_fwd_fpa (
    .mode_i(FWD_MODE_FP), .src_i(fs1), .has_src_i(has_fs1), .stg_rd_i(stg_rd),
    .stg_wen_int_i(stg_wen_int), .stg_wen_fp_i(stg_wen_fp), .sel_o(fwd_fpa)
  );

  ex_fwd_scoreboard_fwd_match #(
    .NUM_FWD_STAGES(NUM_FWD_STAGES), .RIDX_W(RIDX_W), .FWD_W(FWD_W)
  ) u_fwd_fpb (
    .mode_i(FWD_MODE_FP), .src_i(fs2), .has_src_i(has_fs2), .stg_rd_i(stg_rd),
    .stg_wen_int_i(stg_wen_int), .stg_wen_fp_i(stg_wen_fp), .sel_o(fwd_fpb)
  );

  ex_fwd_scoreboard_fwd_match #(
    .NUM_FWD_STAGES(NUM_FWD_STAGES), .RIDX_W(RIDX_W), .FWD_W(FWD_W)
  ) u_fwd_fpc (
    .mode_i(FWD_MODE_FP), .src_i(fs3), .has_src_i(has_fs3), .stg_rd_i(stg_rd),
    .stg_wen_int_i(stg_wen_int), .stg_wen_fp_i(stg_wen_fp), .sel_o(fwd_fpc)
  );

  // Hazards are judged against registered scoreboard state only.
  always_comb begin
    issued    = (iss_state_q == ISS_DONE);
    raw_haz   = (has_fs1 && pending_q[fs1])
             || (has_fs2 && pending_q[fs2])
             || (has_fs3 && pending_q[fs3]);
    waw_haz   = ex_has_fd && pending_q[ex_fd];
    cap_haz   = ex_fp_multi && (outstanding_q == OUT_MAX);
    iss_stall = ex_fp_op && !issued && !fpu_ready;
    stall     = ex_valid && (raw_haz || waw_haz || cap_haz || iss_stall);
    fpu_valid = ex_valid && ex_fp_op && !issued && !flush
             && !raw_haz && !waw_haz && !cap_haz;
    fire      = fpu_valid && fpu_ready;
    set_en    = fire && ex_fp_multi;
    clr_en    = fpu_done && (outstanding_q != '0);
  end

  always_comb begin
    iss_state_d = iss_state_q;
    if (ex_advance || flush) begin
      iss_state_d = ISS_IDLE;
    end else if (fire) begin
      iss_state_d = ISS_DONE;
    end

    pending_d = pending_q;
    if (clr_en) pending_d[fpu_done_fd] = 1'b0;
    if (set_en) pending_d[ex_fd] = 1'b1;

    outstanding_d = outstanding_q;
    case ({set_en, clr_en})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_state_q   <= ISS_IDLE;
      pending_q     <= '0;
      outstanding_q <= '0;
    end else begin
      iss_state_q   <= iss_state_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign outstanding = outstanding_q;

  // A set and a retire of the same register in one cycle means WAW checking broke.
  a_no_set_clr_same: assert property (@(posedge clk) disable iff (!rst_n)
    !(set_en && fpu_done && (ex_fd == fpu_done_fd)));

  a_no_done_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(fpu_done && (outstanding_q == '0)));

endmodule

// File: tb/tb_ex_fwd_scoreboard.sv
module tb_ex_fwd_scoreboard;

  localparam int N     = 2;
  localparam int RW    = 5;
  localparam int FW    = 2;
  localparam int OW    = 3;
  localparam int MAXO  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ex_valid, ex_advance, flush;
  logic [RW-1:0] rs1, rs2, fs1, fs2, fs3, ex_fd, fpu_done_fd;
  logic has_rs1, has_rs2, has_fs1, has_fs2, has_fs3;
  logic ex_fp_op, ex_fp_multi, ex_has_fd;
  logic [N*RW-1:0] stg_rd;
  logic [N-1:0] stg_wen_int, stg_wen_fp;
  logic fpu_ready, fpu_done;
  logic [FW-1:0] fwda, fwdb, fwd_fpa, fwd_fpb, fwd_fpc;
  logic fpu_valid, stall;
  logic [OW-1:0] outstanding;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ex_fwd_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_advance(ex_advance), .flush(flush),
    .rs1(rs1), .rs2(rs2), .has_rs1(has_rs1), .has_rs2(has_rs2),
    .fs1(fs1), .fs2(fs2), .fs3(fs3), .has_fs1(has_fs1), .has_fs2(has_fs2), .has_fs3(has_fs3),
    .ex_fp_op(ex_fp_op), .ex_fp_multi(ex_fp_multi), .ex_fd(ex_fd), .ex_has_fd(ex_has_fd),
    .stg_rd(stg_rd), .stg_wen_int(stg_wen_int), .stg_wen_fp(stg_wen_fp),
    .fpu_ready(fpu_ready), .fpu_done(fpu_done), .fpu_done_fd(fpu_done_fd),
    .fwda(fwda), .fwdb(fwdb), .fwd_fpa(fwd_fpa), .fwd_fpb(fwd_fpb), .fwd_fpc(fwd_fpc),
    .fpu_valid(fpu_valid), .stall(stall), .outstanding(outstanding)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    ex_valid = 0; ex_advance = 0; flush = 0;
    rs1 = 0; rs2 = 0; fs1 = 0; fs2 = 0; fs3 = 0; ex_fd = 0; fpu_done_fd = 0;
    has_rs1 = 0; has_rs2 = 0; has_fs1 = 0; has_fs2 = 0; has_fs3 = 0;
    ex_fp_op = 0; ex_fp_multi = 0; ex_has_fd = 0;
    stg_rd = '0; stg_wen_int = '0; stg_wen_fp = '0;
    fpu_ready = 0; fpu_done = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fp_instr(input logic multi, input logic [RW-1:0] fd, input logic rdy,
                          input logic adv);
    idle();
    ex_valid = 1; ex_fp_op = 1; ex_fp_multi = multi; ex_has_fd = 1; ex_fd = fd;
    fpu_ready = rdy; ex_advance = adv;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, fs1, fs2, fs3;
    logic [4:0] has;  // {fs3, fs2, fs1, rs2, rs1}
    logic [4:0] rd0, rd1;
    logic [1:0] wi, wf;
    int ea, eb, efa, efb, efc;
  } vec_t;

  vec_t vt[9];

  // Reference model state: destinations in flight, and whether the EX op issued.
  int  inflight[$];
  bit  m_issued;

  function automatic bit is_pending(input int r);
    foreach (inflight[i]) if (inflight[i] == r) return 1;
    return 0;
  endfunction

  function automatic int fwd_ref(input int src, input bit has, input bit fp);
    if (!has) return 0;
    if (!fp && src == 0) return 0;
    for (int k = 0; k < N; k++) begin
      if ((fp ? stg_wen_fp[k] : stg_wen_int[k]) && (int'(stg_rd[k*RW +: RW]) == src))
        return k + 1;
    end
    return 0;
  endfunction

  initial begin
    int fires;
    idle();
    rst_n = 0;
    #2;
    check("reset_fpu_valid", fpu_valid, 0);
    check("reset_stall", stall, 0);
    check("reset_outstanding", outstanding, 0);
    @(posedge clk); #1;
    rst_n = 1;
    step();

    // Forwarding vectors (EX idle, purely combinational).
    vt[0] = '{5, 0, 0, 0, 0, 5'b00001, 5, 5,  2'b11, 2'b00, 1, 0, 0, 0, 0};
    vt[1] = '{0, 0, 0, 0, 0, 5'b00011, 0, 0,  2'b11, 2'b11, 0, 0, 0, 0, 0};
    vt[2] = '{0, 0, 0, 3, 0, 5'b01000, 9, 3,  2'b00, 2'b10, 0, 0, 0, 2, 0};
    vt[3] = '{0, 0, 0, 3, 0, 5'b01000, 9, 3,  2'b10, 2'b00, 0, 0, 0, 0, 0};
    vt[4] = '{0, 0, 0, 0, 0, 5'b00100, 0, 1,  2'b00, 2'b01, 0, 0, 1, 0, 0};
    vt[5] = '{7, 7, 0, 0, 7, 5'b10011, 7, 7,  2'b10, 2'b01, 2, 2, 0, 0, 1};
    vt[6] = '{4, 4, 4, 4, 4, 5'b00000, 4, 4,  2'b11, 2'b11, 0, 0, 0, 0, 0};
    vt[7] = '{0, 12, 0, 12, 0, 5'b01010, 3, 12, 2'b10, 2'b00, 0, 2, 0, 0, 0};
    vt[8] = '{0, 0, 6, 0, 0, 5'b00100, 6, 6,  2'b00, 2'b11, 0, 0, 1, 0, 0};
    for (int i = 0; i < 9; i++) begin
      idle();
      rs1 = vt[i].rs1; rs2 = vt[i].rs2; fs1 = vt[i].fs1; fs2 = vt[i].fs2; fs3 = vt[i].fs3;
      {has_fs3, has_fs2, has_fs1, has_rs2, has_rs1} = vt[i].has;
      stg_rd = {vt[i].rd1, vt[i].rd0};
      stg_wen_int = vt[i].wi; stg_wen_fp = vt[i].wf;
      #1;
      check($sformatf("vec%0d_fwda", i), fwda, vt[i].ea);
      check($sformatf("vec%0d_fwdb", i), fwdb, vt[i].eb);
      check($sformatf("vec%0d_fwd_fpa", i), fwd_fpa, vt[i].efa);
      check($sformatf("vec%0d_fwd_fpb", i), fwd_fpb, vt[i].efb);
      check($sformatf("vec%0d_fwd_fpc", i), fwd_fpc, vt[i].efc);
      check($sformatf("vec%0d_stall", i), stall, 0);
    end
    idle();
    step();

    // Single-cycle FADD waiting on fpu_ready: one issue only.
    fires = 0;
    for (int i = 0; i < 3; i++) begin
      fp_instr(0, 2, 0, 0);
      #1;
      check("fadd_wait_valid", fpu_valid, 1);
      check("fadd_wait_stall", stall, 1);
      if (fpu_valid && fpu_ready) fires++;
      step();
    end
    fp_instr(0, 2, 1, 0);
    #1;
    check("fadd_ready_valid", fpu_valid, 1);
    check("fadd_ready_stall", stall, 0);
    if (fpu_valid && fpu_ready) fires++;
    step();
    fp_instr(0, 2, 1, 1);
    #1;
    check("fadd_issued_valid", fpu_valid, 0);
    check("fadd_issued_stall", stall, 0);
    if (fpu_valid && fpu_ready) fires++;
    step();
    idle();
    #1;
    check("fadd_fire_count", fires, 1);
    step();

    // Multi-cycle FMADD fd=7, then a reader of f7 stalls until retire.
    fp_instr(1, 7, 1, 1);
    #1;
    check("fmadd_valid", fpu_valid, 1);
    check("fmadd_out_before", outstanding, 0);
    step();
    fp_instr(0, 8, 1, 0);
    has_fs1 = 1; fs1 = 7;
    #1;
    check("raw_out_1", outstanding, 1);
    check("raw_stall_a", stall, 1);
    check("raw_valid_a", fpu_valid, 0);
    step();
    check("raw_stall_b", stall, 1);
    fpu_done = 1; fpu_done_fd = 7;
    #1;
    check("raw_stall_done_cycle", stall, 1);
    step();
    fpu_done = 0;
    #1;
    check("raw_stall_cleared", stall, 0);
    check("raw_valid_after", fpu_valid, 1);
    check("raw_out_0", outstanding, 0);
    ex_advance = 1;
    step();
    idle();
    step();

    // Capacity: four in flight block a fifth until one retires.
    for (int i = 0; i < 4; i++) begin
      fp_instr(1, 5'(10 + i), 1, 1);
      #1;
      check("cap_fill_valid", fpu_valid, 1);
      step();
    end
    fp_instr(1, 14, 1, 0);
    #1;
    check("cap_out_full", outstanding, 4);
    check("cap_stall", stall, 1);
    check("cap_valid_blocked", fpu_valid, 0);
    fpu_done = 1; fpu_done_fd = 10;
    step();
    fpu_done = 0;
    #1;
    check("cap_out_after_done", outstanding, 3);
    check("cap_valid_free", fpu_valid, 1);
    check("cap_stall_free", stall, 0);
    ex_advance = 1;
    step();
    idle();
    #1;
    check("cap_out_refilled", outstanding, 4);
    for (int r = 11; r <= 14; r++) begin
      fpu_done = 1; fpu_done_fd = 5'(r);
      step();
    end
    fpu_done = 0;
    #1;
    check("cap_drained", outstanding, 0);
    step();

    // Asynchronous reset with work in flight and an issued EX op.
    fp_instr(1, 20, 1, 1); step();
    fp_instr(1, 21, 1, 1); step();
    fp_instr(0, 22, 1, 0); step();
    fpu_ready = 0; has_fs1 = 1; fs1 = 20;
    #1;
    check("pre_rst_out", outstanding, 2);
    check("pre_rst_valid", fpu_valid, 0);
    check("pre_rst_stall", stall, 1);
    rst_n = 0;
    #1;
    check("rst_out", outstanding, 0);
    ex_fp_op = 0;
    #1;
    check("rst_pending_clear", stall, 0);
    ex_fp_op = 1;
    #1;
    check("rst_issued_clear_valid", fpu_valid, 1);
    check("rst_issued_clear_stall", stall, 1);
    ex_valid = 0;
    #1;
    check("rst_idle_valid", fpu_valid, 0);
    check("rst_idle_stall", stall, 0);
    rst_n = 1;
    idle();
    step();

    // Randomized traffic against the reference model.
    inflight.delete();
    m_issued = 0;
    begin
      bit newi = 1;
      for (int c = 0; c < 3000; c++) begin
        bit raw, waw, cap, istl, e_stall, e_valid, fire;
        int di;
        if (newi) begin
          ex_valid = ($urandom % 4) != 0;
          ex_fp_op = $urandom % 2;
          ex_fp_multi = ex_fp_op && ($urandom % 2);
          ex_has_fd = ex_fp_multi ? 1'b1 : 1'($urandom % 2);
          ex_fd = 5'($urandom_range(0, 7));
          rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
          fs1 = 5'($urandom_range(0, 7)); fs2 = 5'($urandom_range(0, 7));
          fs3 = 5'($urandom_range(0, 7));
          {has_fs3, has_fs2, has_fs1, has_rs2, has_rs1} = 5'($urandom);
        end
        stg_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        stg_wen_int = 2'($urandom); stg_wen_fp = 2'($urandom);
        fpu_ready = ($urandom % 3) != 0;
        flush = ($urandom % 16) == 0;
        di = -1;
        fpu_done = 0; fpu_done_fd = 0;
        if (inflight.size() > 0 && ($urandom % 3) == 0) begin
          di = $urandom_range(0, inflight.size() - 1);
          fpu_done = 1; fpu_done_fd = 5'(inflight[di]);
        end

        raw = (has_fs1 && is_pending(fs1)) || (has_fs2 && is_pending(fs2))
           || (has_fs3 && is_pending(fs3));
        waw = ex_has_fd && is_pending(ex_fd);
        cap = ex_fp_multi && (inflight.size() == MAXO);
        istl = ex_fp_op && !m_issued && !fpu_ready;
        e_stall = ex_valid && (raw || waw || cap || istl);
        e_valid = ex_valid && ex_fp_op && !m_issued && !flush && !raw && !waw && !cap;
        ex_advance = ex_valid && !e_stall && ($urandom % 2);
        #1;
        check("rnd_stall", stall, e_stall);
        check("rnd_fpu_valid", fpu_valid, e_valid);
        check("rnd_outstanding", outstanding, inflight.size());
        check("rnd_fwda", fwda, fwd_ref(rs1, has_rs1, 0));
        check("rnd_fwdb", fwdb, fwd_ref(rs2, has_rs2, 0));
        check("rnd_fwd_fpa", fwd_fpa, fwd_ref(fs1, has_fs1, 1));
        check("rnd_fwd_fpb", fwd_fpb, fwd_ref(fs2, has_fs2, 1));
        check("rnd_fwd_fpc", fwd_fpc, fwd_ref(fs3, has_fs3, 1));

        fire = e_valid && fpu_ready;
        if (di >= 0) inflight.delete(di);
        if (fire && ex_fp_multi) inflight.push_back(int'(ex_fd));
        if (ex_advance || flush) m_issued = 0;
        else if (fire) m_issued = 1;
        newi = ex_advance || flush || !ex_valid;
        step();
      end
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
